fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DIV, 61, clk7_en ticks per serial bit; legal range 2..4095.
REQ-002 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 Parameter STOP, 1, stop bits per frame: 1 or 2.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clk7_en  input  1  7MHz clock enable; all state advances only on clk edges with clk7_en=1.
REQ-007 tx_en  input  1  permits starting a new frame.
REQ-008 fifo_data  input  8  head-of-FIFO byte, valid whenever fifo_empty=0 (combinational FIFO read port).
REQ-009 fifo_empty  input  1  upstream FIFO empty flag.
REQ-010 fifo_rd_en  output  1  pop request to upstream FIFO.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 tx_busy  output  1  high while a frame is in progress.
REQ-013 tx_done  output  1  one-clk pulse at end of the last stop bit.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-015 fifo_rd_en SHALL be combinational: (state==IDLE) && tx_en && !fifo_empty.
REQ-016 On a clk7_en edge with fifo_rd_en=1, the block SHALL latch fifo_data into an 8-bit shift register, compute parity, go to START and reset the baud counter; the FIFO pops on the same edge.
REQ-017 Exactly one byte SHALL be popped per frame; no pop while fifo_empty=1 or tx_en=0.
REQ-018 Each bit SHALL last exactly DIV clk7_en ticks; baud counter counts 0..DIV-1 and wraps on the bit boundary.
REQ-019 txd SHALL be registered: 0 in START, shift-register LSB in DATA (LSB first, 8 bits, 3-bit counter), parity bit in PARITY, 1 in STOP and IDLE.
REQ-020 Parity bit SHALL be ~^data for odd, ^data for even.
REQ-021 STOP SHALL last STOP*DIV ticks; on its final tick the block SHALL pulse tx_done for one clk (clk7_en-qualified edge) and return to IDLE.
REQ-022 Frame length SHALL be (9 + (PARITY!=0) + STOP)*DIV clk7_en ticks, start edge to return to IDLE.
REQ-023 If tx_en=1 and fifo_empty=0 in the IDLE cycle following STOP, the next frame SHALL start with no idle bit (back-to-back).
REQ-024 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-025 tx_busy SHALL be registered, 1 in every state except IDLE.
REQ-026 clk edges with clk7_en=0 SHALL change no state, counter, or output; tx_done SHALL be 0.
REQ-027 fifo_data changes while not in IDLE SHALL have no effect on the frame in progress.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, txd=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
REQ-029 rst mid-frame SHALL abort the frame immediately; the popped byte is lost; no pop SHALL occur while rst=1.
REQ-030 After rst release, the first frame SHALL start on the first clk7_en edge meeting REQ-015.

Structure
REQ-031 State encoding and parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) SHALL live in shared package minimig_uart_pkg for reuse by the receive side.
REQ-032 Bit timing SHALL be a sub-module uart_baud_gen (clk, clk7_en, rst, restart, DIV; outputs bit_tick), instantiated once.
REQ-033 Counter widths SHALL derive from DIV via the ceil-log2 helper; no hard-coded widths.

Verification
REQ-034 DIV=4, PARITY=0, STOP=1, FIFO holds 0x55, tx_en=1 -> one pop; txd = 0,1,0,1,0,1,0,1,0,1, each 4 ticks; tx_done after 40 ticks; fifo_empty=1 afterwards.
REQ-035 DIV=4, PARITY=1, STOP=2, byte 0x03 -> parity bit 1, frame 48 ticks, txd high for last 8 ticks.
REQ-036 FIFO holds 0xA5, 0x0F; tx_en=1 -> two frames back-to-back, start bit of frame 2 in the tick after frame 1 stop, exactly two pops.
REQ-037 tx_en dropped at tick 10 of a frame -> frame completes intact; no further pop while FIFO non-empty; resumes when tx_en=1.
REQ-038 rst at tick 17 of a frame -> txd=1, tx_busy=0 asynchronously; no pop during reset; next byte sent cleanly after release.
REQ-039 clk7_en held 0 for 100 clk mid-frame -> txd, state and counters frozen; frame resumes with unchanged bit timing.

Source files
------------

// File: rtl/minimig_uart_pkg.sv
// Shared UART definitions: frame states, parity modes and width helper,
// common to the transmit and receive sides.
package minimig_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Bits needed to hold values 0..v-1; never less than one.
  function automatic int unsigned ceil_log2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk7_en ticks 0..DIV-1 and flags the last tick of
// each bit; restart re-aligns the period to a new frame.
module uart_baud_gen
  import minimig_uart_pkg::*;
#(
  parameter int unsigned DIV = 61
) (
  input  logic clk,
  input  logic clk7_en,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned     CntW   = ceil_log2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clk7_en) begin
      if (restart || (cnt_q == CntMax)) cnt_d = '0;
      else                              cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_tick = clk7_en && !restart && (cnt_q == CntMax);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a show-ahead FIFO: pops one byte per frame and
// serialises start, 8 data bits LSB first, optional parity and stop bits.
module fifo_uart_tx
  import minimig_uart_pkg::*;
#(
  parameter int unsigned DIV    = 61,
  parameter int unsigned PARITY = 0,
  parameter int unsigned STOP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk7_en,
  input  logic       tx_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned         BitCntW  = ceil_log2(8);
  localparam int unsigned         StopCntW = ceil_log2(STOP + 1);
  localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(7);
  localparam logic [StopCntW-1:0] StopLast = StopCntW'(STOP - 1);

  uart_state_e         state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [StopCntW-1:0] stop_cnt_q, stop_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                bit_tick;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk     (clk),
    .clk7_en (clk7_en),
    .rst     (rst),
    .restart (fifo_rd_en),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  // txd is registered, so each transition loads the level of the bit being entered.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    if (clk7_en) begin
      unique case (state_q)
        StIdle: begin
          if (fifo_rd_en) begin
            state_d    = StStart;
            shift_d    = fifo_data;
            par_d      = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
            txd_d      = 1'b0;
            busy_d     = 1'b1;
          end
        end
        StStart: begin
          if (bit_tick) begin
            state_d = StData;
            txd_d   = shift_q[0];
          end
        end
        StData: begin
          if (bit_tick) begin
            if (bit_cnt_q == BitLast) begin
              bit_cnt_d = '0;
              if (PARITY != PAR_NONE) begin
                state_d = StParity;
                txd_d   = par_q;
              end else begin
                state_d = StStop;
                txd_d   = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
              shift_d   = shift_q >> 1;
              txd_d     = shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_tick) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end
        end
        StStop: begin
          if (bit_tick) begin
            if (stop_cnt_q == StopLast) begin
              state_d    = StIdle;
              stop_cnt_d = '0;
              busy_d     = 1'b0;
            end else begin
              stop_cnt_d = stop_cnt_q + StopCntW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // rst gates the pop so an asserted reset can never drain the FIFO.
  always_comb begin
    fifo_rd_en = (state_q == StIdle) && tx_en && !fifo_empty && !rst;
    tx_done    = (state_q == StStop) && bit_tick && (stop_cnt_q == StopLast);
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;

endmodule
